// File: rtl/apb_slv_pkg.sv
// Shared types and register indices for the APB completer register bank.
package apb_slv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_WAIT  = 2'b01,
      ST_READY = 2'b10
   } apb_slv_state_t;

   localparam int unsigned REG_ID   = 0;
   localparam int unsigned REG_STAT = 1;

endpackage

// File: rtl/apb_slv_regfile.sv
// Word register storage with read-only ID/STAT slots and a combinational read mux.
module apb_slv_regfile
   import apb_slv_pkg::*;
#(
   parameter int unsigned     DATA_W   = 32,
   parameter int unsigned     NUM_REGS = 8,
   parameter int unsigned     IDX_W    = $clog2(NUM_REGS),
   parameter logic [DATA_W-1:0] ID_VALUE = 32'hA9B5_0001
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_we,
   input  logic [IDX_W-1:0]           i_widx,
   input  logic [DATA_W-1:0]          i_wdata,
   input  logic [IDX_W-1:0]           i_ridx,
   input  logic [DATA_W-1:0]          i_stat,
   output logic [DATA_W-1:0]          o_rdata,
   output logic [NUM_REGS*DATA_W-1:0] o_regs
);

   logic [DATA_W-1:0] r_mem [2:NUM_REGS-1];
   logic [DATA_W-1:0] w_view [NUM_REGS];

   // Slots 0 and 1 have no storage; the guard keeps stray writes harmless.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 2; i < NUM_REGS; i++) r_mem[i] <= '0;
      end else if (i_we && (i_widx >= IDX_W'(2))) begin
         r_mem[i_widx] <= i_wdata;
      end
   end

   always_comb begin
      w_view[REG_ID]   = ID_VALUE;
      w_view[REG_STAT] = i_stat;
      for (int i = 2; i < NUM_REGS; i++) w_view[i] = r_mem[i];
   end

   assign o_rdata = w_view[i_ridx];

   always_comb begin
      o_regs = '0;
      for (int i = 0; i < NUM_REGS; i++) o_regs[i*DATA_W +: DATA_W] = w_view[i];
   end

endmodule

// File: rtl/apb_slave_regs.sv
// APB3 completer owning a small word register bank, with programmable wait states
// and pslverr on out-of-window accesses or writes to the read-only slots.
module apb_slave_regs
   import apb_slv_pkg::*;
#(
   parameter int unsigned       DATA_W      = 32,
   parameter int unsigned       NUM_REGS    = 8,
   parameter logic [31:0]       BASE_ADDR   = 32'hDEAD_CAE0,
   parameter int unsigned       WAIT_CYCLES = 2,
   parameter logic [DATA_W-1:0] ID_VALUE    = 32'hA9B5_0001
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       psel_i,
   input  logic                       penable_i,
   input  logic [31:0]                paddr_i,
   input  logic                       pwrite_i,
   input  logic [DATA_W-1:0]          pwdata_i,
   output logic                       pready_o,
   output logic [DATA_W-1:0]          prdata_o,
   output logic                       pslverr_o,
   output logic [NUM_REGS*DATA_W-1:0] regs_o
);

   localparam int unsigned IDX_W = $clog2(NUM_REGS);

   apb_slv_state_t     r_state;
   logic [3:0]         r_cnt;
   logic [IDX_W-1:0]   r_idx;
   logic               r_write;
   logic [DATA_W-1:0]  r_wdata;
   logic               r_err;
   logic               r_pready;
   logic [DATA_W-1:0]  r_prdata;
   logic               r_pslverr;
   logic [15:0]        r_wr_cnt;
   logic [15:0]        r_rd_cnt;

   logic               w_setup;
   logic               w_hit;
   logic [IDX_W-1:0]   w_addr_idx;
   logic               w_addr_err;
   logic               w_cur_err;
   logic               w_cur_write;
   logic [IDX_W-1:0]   w_rd_idx;
   logic [DATA_W-1:0]  w_rdata;
   logic [DATA_W-1:0]  w_load_data;
   logic               w_commit;
   logic               w_we;
   logic [DATA_W-1:0]  w_stat;
   logic               w_unused_addr;

   assign w_unused_addr = ^paddr_i[1:0];
   assign w_setup       = psel_i & ~penable_i;
   assign w_hit         = paddr_i[31:IDX_W+2] == BASE_ADDR[31:IDX_W+2];
   assign w_addr_idx    = paddr_i[IDX_W+1:2];
   assign w_addr_err    = ~w_hit | (pwrite_i & ((w_addr_idx == IDX_W'(REG_ID)) |
                                                (w_addr_idx == IDX_W'(REG_STAT))));

   // With zero wait states the response is loaded on the setup edge itself, before latching.
   assign w_cur_err   = (r_state == ST_IDLE) ? w_addr_err : r_err;
   assign w_cur_write = (r_state == ST_IDLE) ? pwrite_i   : r_write;
   assign w_rd_idx    = (r_state == ST_IDLE) ? w_addr_idx : r_idx;
   assign w_load_data = (w_cur_err | w_cur_write) ? '0 : w_rdata;

   assign w_commit = (r_state == ST_READY) & psel_i & penable_i & r_pready & ~r_err;
   assign w_we     = w_commit & r_write;
   assign w_stat   = DATA_W'({r_wr_cnt, r_rd_cnt});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_write   <= 1'b0;
         r_wdata   <= '0;
         r_err     <= 1'b0;
         r_pready  <= 1'b0;
         r_prdata  <= '0;
         r_pslverr <= 1'b0;
         r_wr_cnt  <= '0;
         r_rd_cnt  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_setup) begin
                  r_idx   <= w_addr_idx;
                  r_write <= pwrite_i;
                  r_wdata <= pwdata_i;
                  r_err   <= w_addr_err;
                  if (WAIT_CYCLES == 0) begin
                     r_state   <= ST_READY;
                     r_pready  <= 1'b1;
                     r_prdata  <= w_load_data;
                     r_pslverr <= w_cur_err;
                  end else begin
                     r_state <= ST_WAIT;
                     r_cnt   <= 4'(WAIT_CYCLES - 1);
                  end
               end
            end
            ST_WAIT: begin
               if (!psel_i) begin
                  r_state <= ST_IDLE;
               end else if (r_cnt == '0) begin
                  r_state   <= ST_READY;
                  r_pready  <= 1'b1;
                  r_prdata  <= w_load_data;
                  r_pslverr <= w_cur_err;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_READY: begin
               r_state   <= ST_IDLE;
               r_pready  <= 1'b0;
               r_prdata  <= '0;
               r_pslverr <= 1'b0;
               if (w_commit) begin
                  if (r_write) r_wr_cnt <= r_wr_cnt + 16'd1;
                  else         r_rd_cnt <= r_rd_cnt + 16'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   apb_slv_regfile #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W),
      .ID_VALUE (ID_VALUE)
   ) u_regfile (
      .i_clk   (clk),
      .i_reset (reset),
      .i_we    (w_we),
      .i_widx  (r_idx),
      .i_wdata (r_wdata),
      .i_ridx  (w_rd_idx),
      .i_stat  (w_stat),
      .o_rdata (w_rdata),
      .o_regs  (regs_o)
   );

   assign pready_o  = r_pready;
   assign prdata_o  = r_prdata;
   assign pslverr_o = r_pslverr;

endmodule

// File: tb/tb_apb_slave_regs.sv
// Scoreboard bench: drivers queue expected responses, monitors check them on each pready.
module tb_apb_slave_regs;

   typedef struct {
      string       name;
      logic [31:0] data;
      bit          chk_data;
      bit          err;
      int          waits;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         psel0 = 1'b0, psel1 = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [31:0]  paddr = '0, pwdata = '0;
   logic         pready0, pslverr0, pready1, pslverr1;
   logic [31:0]  prdata0, prdata1;
   logic [255:0] regs0, regs1;

   exp_t q0[$];
   exp_t q1[$];
   int   n_tests = 0;
   int   n_fail = 0;
   int   w0 = 0;
   int   w1 = 0;

   apb_slave_regs #(.WAIT_CYCLES(2)) u_dut0 (
      .clk(clk), .reset(reset), .psel_i(psel0), .penable_i(penable), .paddr_i(paddr),
      .pwrite_i(pwrite), .pwdata_i(pwdata), .pready_o(pready0), .prdata_o(prdata0),
      .pslverr_o(pslverr0), .regs_o(regs0)
   );

   apb_slave_regs #(.WAIT_CYCLES(0)) u_dut1 (
      .clk(clk), .reset(reset), .psel_i(psel1), .penable_i(penable), .paddr_i(paddr),
      .pwrite_i(pwrite), .pwdata_i(pwdata), .pready_o(pready1), .prdata_o(prdata1),
      .pslverr_o(pslverr1), .regs_o(regs1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic mon_hit(input int d, input logic [31:0] rd, input logic err, input int waits);
      exp_t e;
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
         chk($sformatf("dut%0d unexpected pready", d), 32'd1, 32'd0);
         return;
      end
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      if (e.chk_data) chk({e.name, " prdata"}, rd, e.data);
      chk({e.name, " pslverr"}, {31'b0, err}, {31'b0, e.err});
      chk({e.name, " wait cycles"}, waits, e.waits);
   endtask

   always @(negedge clk) begin
      if (reset || !psel0) w0 = 0;
      else if (penable) begin
         if (pready0) begin mon_hit(0, prdata0, pslverr0, w0); w0 = 0; end
         else w0++;
      end
      if (reset || !psel1) w1 = 0;
      else if (penable) begin
         if (pready1) begin mon_hit(1, prdata1, pslverr1, w1); w1 = 0; end
         else w1++;
      end
   end

   // Called at posedge+1; leaves the bus idle at posedge+1 after the completing edge.
   task automatic xfer(input int d, input string name, input logic [31:0] addr, input bit wr,
                       input logic [31:0] wd, input logic [31:0] exp_d, input bit exp_err);
      exp_t e;
      int   n;
      e = '{name, exp_d, !wr, exp_err, (d == 0) ? 2 : 0};
      if (d == 0) q0.push_back(e); else q1.push_back(e);
      psel0 = (d == 0); psel1 = (d == 1); penable = 1'b0;
      paddr = addr; pwrite = wr; pwdata = wd;
      @(posedge clk); #1 penable = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (((d == 0) ? pready0 : pready1) !== 1'b1 && n < 20);
      if (n >= 20) begin
         chk({name, " timeout waiting for pready"}, 32'd0, 32'd1);
         if (d == 0) q0.delete(); else q1.delete();
      end
      @(posedge clk); #1;
      psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
   endtask

   initial begin
      @(posedge clk); #1;
      chk("reset pready", {31'b0, pready0}, 32'd0);
      chk("reset prdata", prdata0, 32'd0);
      chk("reset pslverr", {31'b0, pslverr0}, 32'd0);
      chk("reset regs 2..7", {16'b0, 16'(|regs0[255:64])}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      xfer(0, "read ID", 32'hDEAD_CAE0, 1'b0, 32'h0, 32'hA9B5_0001, 1'b0);
      xfer(0, "write reg7", 32'hDEAD_CAFE, 1'b1, 32'h1234_5678, 32'h0, 1'b0);
      chk("regs_o[7] after write", regs0[7*32 +: 32], 32'h1234_5678);
      xfer(0, "read STAT", 32'hDEAD_CAE4, 1'b0, 32'h0, 32'h0001_0001, 1'b0);
      xfer(0, "read back reg7", 32'hDEAD_CAFC, 1'b0, 32'h0, 32'h1234_5678, 1'b0);

      xfer(0, "preload reg7", 32'hDEAD_CAFE, 1'b1, 32'h0000_00FF, 32'h0, 1'b0);
      xfer(0, "master read reg7", 32'hDEAD_CAFE, 1'b0, 32'h0, 32'h0000_00FF, 1'b0);
      xfer(0, "master write inc", 32'hDEAD_CAFE, 1'b1, 32'h0000_0100, 32'h0, 1'b0);
      chk("regs_o[7] after increment", regs0[7*32 +: 32], 32'h0000_0100);

      xfer(0, "write STAT err", 32'hDEAD_CAE4, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1);
      xfer(0, "read miss err", 32'h0000_1000, 1'b0, 32'h0, 32'h0, 1'b1);
      xfer(0, "write ID err", 32'hDEAD_CAE0, 1'b1, 32'h5555_5555, 32'h0, 1'b1);
      chk("regs_o[0] ID", regs0[0 +: 32], 32'hA9B5_0001);
      chk("regs_o[1] STAT unchanged by errors", regs0[32 +: 32], 32'h0003_0004);
      xfer(0, "read STAT after errors", 32'hDEAD_CAE4, 1'b0, 32'h0, 32'h0003_0004, 1'b0);

      // Master abort: write setup to reg2, drop psel while the completer is still waiting.
      psel0 = 1'b1; penable = 1'b0; paddr = 32'hDEAD_CAE8; pwrite = 1'b1; pwdata = 32'hCAFE;
      @(posedge clk); #1 penable = 1'b1;
      @(posedge clk); #1 psel0 = 1'b0; penable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort no pready", {31'b0, pready0}, 32'd0);
      end
      chk("abort reg2 unchanged", regs0[2*32 +: 32], 32'd0);
      @(posedge clk); #1;
      xfer(0, "read reg2 after abort", 32'hDEAD_CAE8, 1'b0, 32'h0, 32'h0, 1'b0);

      // Asynchronous reset while a write to reg3 is waiting.
      psel0 = 1'b1; penable = 1'b0; paddr = 32'hDEAD_CAEC; pwrite = 1'b1; pwdata = 32'hBEEF;
      @(posedge clk); #1 penable = 1'b1;
      @(posedge clk); #1 reset = 1'b1;
      #2;
      chk("mid reset pready", {31'b0, pready0}, 32'd0);
      chk("mid reset prdata", prdata0, 32'd0);
      chk("mid reset pslverr", {31'b0, pslverr0}, 32'd0);
      chk("mid reset STAT", regs0[32 +: 32], 32'd0);
      chk("mid reset reg7", regs0[7*32 +: 32], 32'd0);
      psel0 = 1'b0; penable = 1'b0;
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1;
      chk("reg3 after reset", regs0[3*32 +: 32], 32'd0);
      xfer(0, "read reg3 after reset", 32'hDEAD_CAEC, 1'b0, 32'h0, 32'h0, 1'b0);

      xfer(1, "zw write reg5", 32'hDEAD_CAF4, 1'b1, 32'h0000_A5A5, 32'h0, 1'b0);
      chk("zw regs_o[5]", regs1[5*32 +: 32], 32'h0000_A5A5);
      xfer(1, "zw read reg5", 32'hDEAD_CAF4, 1'b0, 32'h0, 32'h0000_A5A5, 1'b0);
      xfer(1, "zw read ID", 32'hDEAD_CAE0, 1'b0, 32'h0, 32'hA9B5_0001, 1'b0);
      xfer(1, "zw write miss err", 32'h1EAD_CAF4, 1'b1, 32'h1, 32'h0, 1'b1);

      repeat (2) @(posedge clk);
      chk("dut0 scoreboard drained", q0.size(), 32'd0);
      chk("dut1 scoreboard drained", q1.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
